// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer family:
// selection-mode encodings and the grant FSM state type.
package stream_mux_rr_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter. The search starts one past
// last_grant and wraps modulo N_CH, so non-power-of-2 channel counts
// wrap correctly. last_grant must be < N_CH.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // One spare bit holds last_grant + offset before the modulo fold.
  logic [SEL_W:0]   sum     [N_CH];
  logic [SEL_W-1:0] rot_idx [N_CH];

  // rot_idx[i] is the channel examined at priority position i.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
    assign sum[gi]     = {1'b0, last_grant} + (SEL_W+1)'(gi + 1);
    assign rot_idx[gi] = (sum[gi] >= (SEL_W+1)'(N_CH))
                         ? SEL_W'(sum[gi] - (SEL_W+1)'(N_CH))
                         : sum[gi][SEL_W-1:0];
  end

  // Scan lowest priority first so the highest-priority requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[rot_idx[i]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rot_idx[i];
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with manual or round-robin
// selection, packet locking until the last beat, and a registered output.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   last_grant_q, last_grant_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;

  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [SEL_W-1:0]   out_ch_q;

  logic               load_en;
  logic               rr_valid;
  logic [SEL_W-1:0]   rr_idx;
  logic               cand_valid;
  logic [SEL_W-1:0]   cand_idx;
  logic [DATA_W-1:0]  cand_data;
  logic               cand_last;
  logic               accept;

  rr_arbiter #(
    .N_CH(N_CH)
  ) u_arb (
    .req       (in_valid),
    .last_grant(last_grant_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // The output slot can take a beat when empty or draining this cycle.
  assign load_en = ~out_valid_q | out_ready;

  // Pick the channel allowed to transfer: the locked one, else per mode.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    if (state_q == ST_LOCKED) begin
      cand_valid = 1'b1;
      cand_idx   = lock_ch_q;
    end else if (mode == MODE_MANUAL) begin
      // Out-of-range select values match no channel and grant nothing.
      for (int k = 0; k < N_CH; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          cand_valid = 1'b1;
          cand_idx   = sel;
        end
      end
    end else begin
      cand_valid = rr_valid;
      cand_idx   = rr_idx;
    end
  end

  // At most one ready bit, and none while reset is asserted.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready[gi] = rst_n & cand_valid & load_en & (cand_idx == SEL_W'(gi));
  end

  // Route the candidate channel's payload toward the output register.
  always_comb begin
    cand_data = '0;
    cand_last = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (cand_idx == SEL_W'(k)) begin
        cand_data = in_data[k*DATA_W +: DATA_W];
        cand_last = in_last[k];
      end
    end
  end

  assign accept = |(in_valid & in_ready);

  // Next-state: lock on a non-final beat, release and record the grant on the last.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_ch_d    = lock_ch_q;
    if (accept) begin
      if (cand_last) begin
        state_d      = ST_IDLE;
        last_grant_d = cand_idx;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = cand_idx;
      end
    end
  end

  // FSM and arbitration history registers; reset gives channel 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SEL_W'(N_CH - 1);
      lock_ch_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  // Output register: load on accept, drop valid once drained, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= cand_data;
      out_last_q  <= cand_last;
      out_ch_q    <= cand_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios with constant
// expectations, a randomized run against a behavioural model, and a
// 3-channel instance for non-power-of-2 wrap and out-of-range select.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid, out_last, out_ready;
  logic [SW-1:0]   out_ch;

  // 3-channel instance
  logic            rst3_n;
  logic            mode3;
  logic [1:0]      sel3;
  logic [3*W-1:0]  in_data3;
  logic [2:0]      in_valid3, in_last3, in_ready3;
  logic [W-1:0]    out_data3;
  logic            out_valid3, out_last3, out_ready3;
  logic [1:0]      out_ch3;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state (lock = -1 means no packet in progress).
  int          m_lock;
  int          m_lg;
  bit          m_ov;
  bit          m_ol;
  logic [W-1:0] m_od;
  int          m_och;

  stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(W)) dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  // Channel the rules allow to transfer now, or -1.
  function automatic int m_cand();
    if (m_lock >= 0) return m_lock;
    if (mode == 1'b1) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_lg + i) % N;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(sel) < N && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int c;
    c = m_cand();
    if (!rst_n || c < 0 || !(!m_ov || out_ready)) return '0;
    return N'(1) << c;
  endfunction

  // Advance one clock and update the model from the inputs seen before the edge.
  task automatic tick();
    int c;
    bit acc;
    logic [W-1:0] d;
    bit l;
    c   = m_cand();
    acc = 1'b0;
    d   = '0;
    l   = 1'b0;
    if (c >= 0) begin
      acc = rst_n && (!m_ov || out_ready) && in_valid[c];
      d   = in_data[c*W +: W];
      l   = in_last[c];
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ov = 0; m_ol = 0; m_od = '0; m_och = 0; m_lock = -1; m_lg = N - 1;
    end else if (acc) begin
      m_ov = 1; m_od = d; m_ol = l; m_och = c;
      if (l) begin m_lock = -1; m_lg = c; end
      else m_lock = c;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; in_valid = '1; in_last = '1; in_data = 32'h13121110; out_ready = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ready: got %b want 0000", in_ready);
    end
    n_cmp++;
    if ({out_valid, out_last, out_ch, out_data} !== 12'h000) begin
      n_bad++; $display("FAIL reset_out: got v=%b l=%b ch=%0d d=%02h want all 0", out_valid, out_last, out_ch, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_last = 4'b1111;
    in_data = 32'h33A51100; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++; $display("FAIL manual_ready: got %b want 0100", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_last, out_ch, out_data} !== {1'b1, 1'b1, 2'd2, 8'hA5}) begin
      n_bad++; $display("FAIL manual_out: got v=%b l=%b ch=%0d d=%02h want v=1 l=1 ch=2 d=a5", out_valid, out_last, out_ch, out_data);
    end
    in_valid = 4'b0000;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL manual_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, SW'(i % 4), 8'h10 + 8'(i % 4)}) begin
        n_bad++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%02h want v=1 ch=%0d d=%02h", i, out_valid, out_ch, out_data, i % 4, 8'h10 + 8'(i % 4));
      end
    end
  endtask

  task automatic test_packet_lock();
    int b;
    bit acc1;
    int exp_ch [6] = '{0, 1, 1, 1, 3, 0};
    logic [7:0] exp_d [6] = '{8'h0A, 8'h11, 8'h12, 8'h13, 8'h3C, 8'h0A};
    do_reset();
    b = 0;
    mode = 1'b1; out_ready = 1'b1;
    in_valid = 4'b1011; in_last = 4'b1001; in_data = 32'h3C00110A;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if ($countones(in_ready) > 1) begin
        n_bad++; $display("FAIL lock_onehot[%0d]: got %b want at most one bit", i, in_ready);
      end
      acc1 = in_ready[1] & in_valid[1];
      tick();
      if (acc1) b++;
      in_data[15:8] = 8'h11 + 8'(b);
      in_last[1]    = (b == 2);
      in_valid[1]   = (b < 3);
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, SW'(exp_ch[i]), exp_d[i]}) begin
        n_bad++; $display("FAIL lock_seq[%0d]: got v=%b ch=%0d d=%02h want v=1 ch=%0d d=%02h", i, out_valid, out_ch, out_data, exp_ch[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = 4'b1111; in_data = 32'h00000055; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_data = 32'h00000066;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_data} !== {1'b1, 8'h55}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%02h want v=1 d=55", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL bp_release_ready: got %b want 0001", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 8'h66}) begin
      n_bad++; $display("FAIL bp_next: got v=%b d=%02h want v=1 d=66", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h00210000; out_ready = 1'b1;
    tick();
    in_data = 32'h00220000;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_ready: got %b want 0000", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_ch} !== {1'b0, 2'd0}) begin
      n_bad++; $display("FAIL rstmid_out: got v=%b ch=%0d want v=0 ch=0", out_valid, out_ch);
    end
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b0101; in_last = 4'b0101; in_data = 32'h00320030;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL rstmid_grant_ready: got %b want 0001", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'h30}) begin
      n_bad++; $display("FAIL rstmid_grant: got v=%b ch=%0d d=%02h want v=1 ch=0 d=30", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    logic [W+SW+1:0] exp_o;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      #1;
      exp_r = m_ready();
      n_cmp++;
      if (in_ready !== exp_r) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, in_ready, exp_r);
      end
      n_cmp++;
      if ($countones(in_ready) > 1) begin
        n_bad++; $display("FAIL rand_onehot[%0d]: got %b want at most one bit", cyc, in_ready);
      end
      if (rst_n && out_valid && out_ready)
        $display("beat cyc=%0d ch=%0d data=%02h last=%0b", cyc, out_ch, out_data, out_last);
      tick();
      exp_o = {m_ov, m_ol, SW'(m_och), m_od};
      n_cmp++;
      if ({out_valid, out_last, out_ch, out_data} !== exp_o) begin
        n_bad++; $display("FAIL rand_out[%0d]: got %h want %h", cyc, {out_valid, out_last, out_ch, out_data}, exp_o);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_edge_n3();
    rst3_n = 1'b0; mode3 = 1'b1; sel3 = 2'd0; in_valid3 = 3'b000; in_last3 = 3'b111;
    in_data3 = 24'hC2B1A0; out_ready3 = 1'b1;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    in_valid3 = 3'b101;
    #1;
    n_cmp++;
    if (in_ready3 !== 3'b001) begin
      n_bad++; $display("FAIL n3_wrap_ready: got %b want 001", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd0, 8'hA0}) begin
      n_bad++; $display("FAIL n3_wrap_out: got v=%b ch=%0d d=%02h want v=1 ch=0 d=a0", out_valid3, out_ch3, out_data3);
    end
    n_cmp++;
    if (in_ready3 !== 3'b100) begin
      n_bad++; $display("FAIL n3_next_ready: got %b want 100", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_ch3, out_data3} !== {2'd2, 8'hC2}) begin
      n_bad++; $display("FAIL n3_next_out: got ch=%0d d=%02h want ch=2 d=c2", out_ch3, out_data3);
    end
    n_cmp++;
    if (in_ready3 !== 3'b001) begin
      n_bad++; $display("FAIL n3_rewrap_ready: got %b want 001", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_ch3 !== 2'd0) begin
      n_bad++; $display("FAIL n3_rewrap_out: got ch=%0d want 0", out_ch3);
    end
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    n_cmp++;
    if (in_ready3 !== 3'b000) begin
      n_bad++; $display("FAIL n3_badsel_ready: got %b want 000", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid3 !== 1'b0) begin
      n_bad++; $display("FAIL n3_badsel_out: got out_valid=%b want 0", out_valid3);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    rst3_n = 1'b0; mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b0;
    m_lock = -1; m_lg = N - 1; m_ov = 0; m_ol = 0; m_od = '0; m_och = 0;
    #2;
    test_reset();
    test_manual();
    test_rr_fairness();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    test_edge_n3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer with valid/ready handshake on every input and on the output. It succeeds the 4:1 combinational mux.
- Two selection modes:
  - manual: external select, like the 4:1 mux.
  - round-robin: fair arbitration.
- Packet lock: once a channel is granted, it keeps the output until its last-flagged beat transfers.
- Output is registered. Sits between multiple producers (e.g. UART/sensor frame sources) and a single consumer.

Parameters:
- N_CH, 4, number of input channels (2..16, need not be a power of 2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of the select and channel-id fields (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = manual select, 1 = round-robin.
- sel  in  SEL_W  channel index used in manual mode.
- in_data  in  N_CH*DATA_W  flattened input data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel ready (combinational).
- out_data  out  DATA_W  registered output data.
- out_valid  out  1  registered output valid.
- out_last  out  1  registered end-of-packet flag.
- out_ch  out  SEL_W  index of the channel that produced the current output beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - state=IDLE, last_grant=N_CH-1 so that channel 0 has first priority.
  - in_ready is forced to all-0 while rst_n=0.
  - A reset mid-packet drops the packet with no flush.
- Slot free: load_en = ~out_valid | out_ready.
- Beat accepted on channel g when in_valid[g] & in_ready[g]. That beat loads out_data/out_last/out_ch on the same edge and sets out_valid=1.
  - Latency: 1 clk from input acceptance to out_valid.
  - Throughput: 1 beat/clk while out_ready=1.
- If out_valid=1 and out_ready=0: out_data, out_last and out_ch hold stable; no input is accepted.
- If out_valid=1, out_ready=1 and no new beat is accepted: out_valid clears to 0 on the next edge.
- State machine:
  - IDLE, candidate selection:
    - manual: candidate = sel, provided sel < N_CH and in_valid[sel]=1. sel >= N_CH gives no grant.
    - round-robin: first valid channel, searching from (last_grant+1) mod N_CH upward with wrap-around. Wrap must be correct for non-power-of-2 N_CH.
  - IDLE, handshake:
    - in_ready[candidate] = load_en; all other in_ready = 0. No candidate means in_ready all 0.
    - Accepted beat with in_last=1: remain in IDLE, last_grant <= g (single-beat packet).
    - Accepted beat with in_last=0: go to LOCKED, lock_ch <= g.
  - LOCKED:
    - in_ready[lock_ch] = load_en; all other in_ready = 0.
    - mode and sel are ignored.
    - Accepted beat with in_last=1: go to IDLE, last_grant <= lock_ch.
    - in_valid[lock_ch]=0: hold LOCKED with no timeout.
- Simultaneous events:
  - Grant and downstream drain in the same cycle are allowed. Output reloads with no bubble.
  - A mode or sel change in IDLE takes effect in the same cycle's candidate selection.
  - last_grant is updated in manual mode too, so switching to round-robin continues fairly.
- At most one in_ready bit is high in any cycle (one-hot or zero).

Decomposition:
- Shared header mux_defs.vh holds:
  - MODE_MANUAL=1'b0, MODE_RR=1'b1.
  - State encodings ST_IDLE, ST_LOCKED.
- Sub-module rr_arbiter:
  - Parameter N_CH.
  - Inputs: req[N_CH-1:0], last_grant.
  - Outputs: gnt_valid, gnt_idx (combinational rotate-priority search).
  - Reusable by other arbitrated blocks.
- The top level holds the FSM, the output register and in_ready generation.

Test Plan:
- Manual pass-through: mode=0, sel=2, ch2 sends 0xA5 (last=1), out_ready=1 -> one cycle later out_valid=1, out_data=0xA5, out_ch=2, out_last=1; in_ready[0,1,3]=0 throughout.
- Round-robin fairness: mode=1, all four channels continuously valid with single-beat packets (data=0x10+k) -> out_ch sequence 0,1,2,3,0,... with one beat per clk.
- Packet lock: ch1 sends a 3-beat packet 0x11,0x12,0x13 (last on the third) while ch0 and ch3 are valid -> out_ch=1 for three consecutive beats, then the grant moves to ch3 (next after 1 with valid), then ch0.
- Backpressure: out_ready=0 for 4 clks with out_valid=1, out_data=0x55 -> out_data stays 0x55, all in_ready=0; out_ready=1 -> 0x55 transfers and the next beat follows on the following clk.
- Reset mid-packet: rst_n=0 for 1 clk after beat 2 of 4 on ch2 -> out_valid=0, state IDLE, out_ch=0; afterwards ch0 and ch2 both valid -> ch0 granted first.
- Edge cases: N_CH=3, mode=1, ch2 and ch0 valid with last_grant=2 -> ch0 granted (wrap); mode=0 with sel=3 -> no grant and in_ready all 0.
